sd_reg_bank: RTL
================

# sd_reg_bank

Parametrised host-facing register bank for the SD host controller, successor to the flat byte register set. Adds per-register access modes (read/write, read-only, write-1-to-clear), per-register reset values, a hardware update path for status registers, and programmable response latency. It uses a four-phase req/ack handshake with error reporting. It sits between the host bus adapter and the command/data engines, which consume the flattened register image and the write strobes.

## Interface
- DATA_WIDTH, 8, register width in bits.
- ADDR_WIDTH, 4, address width.
- NUM_REGS, 16, implemented registers; NUM_REGS ≤ 2**ADDR_WIDTH.
- ACK_LATENCY, 1, cycles from accepted req to ack; legal 1..4.
- RESET_VALUES, 0, DATA_WIDTH*NUM_REGS packed reset values; register i occupies slice [DATA_WIDTH*i +: DATA_WIDTH].
- RO_MASK, 0, NUM_REGS bits; bit i set makes register i read-only to the host.
- W1C_MASK, 0, NUM_REGS bits; bit i set makes register i write-1-to-clear. RO_MASK takes precedence where both bits are set.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high until ack, then dropped.
- wnr  in  1  1 = write, 0 = read; stable while req is high.
- address  in  ADDR_WIDTH  register index.
- data_in  in  DATA_WIDTH  write data.
- hw_set  in  NUM_REGS  per-register hardware update strobe.
- hw_data  in  DATA_WIDTH*NUM_REGS  hardware update values, sliced like RESET_VALUES.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; address ≥ NUM_REGS.
- data_out  out  DATA_WIDTH  read data.
- wr_pulse  out  NUM_REGS  one-cycle strobe for each host-written register.
- mem_data_out  out  DATA_WIDTH*NUM_REGS  live flattened register image.

## Operation
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE: on req=1, latch wnr, address and data_in. Go to ACK if ACK_LATENCY=1, otherwise to WAIT with the counter loaded to ACK_LATENCY-2.
  - WAIT: decrement the counter; at 0, go to ACK.
  - ACK: ack=1 for exactly one cycle, then go to HOLD.
  - HOLD: wait for req=0, then return to IDLE. An access is accepted at most once per req assertion.
- Write access, committed on the edge that enters ACK:
  - RW register: the register takes the latched data_in.
  - W1C register: bits written as 1 clear; bits written as 0 are unchanged.
  - RO register: the register is unchanged, err=0.
  - wr_pulse[i] pulses during the ACK cycle for RW and W1C targets only.
- Read access: data_out is loaded on the edge entering ACK and holds until the next read completes. Reads have no side effects.
- Out-of-range address: err=1 with ack. Writes are discarded; reads return data_out=0.
- hw_set[i] is applied every cycle, independent of the FSM:
  - RO register: the register takes hw_data slice i.
  - W1C register: register |= hw_data slice i.
  - RW register: the register takes hw_data slice i.
- Same-edge collisions:
  - RW register: a host write beats hw_set.
  - W1C register: a set beats a clear, bitwise.
- Reset (asynchronous, low): all registers take RESET_VALUES; FSM goes to IDLE; ack, err, data_out and wr_pulse are 0. A transaction interrupted by reset is dropped and the host must re-issue it.

## Timing
- req first sampled high at edge N: ack is high in the cycle after edge N+ACK_LATENCY-1, i.e. ACK_LATENCY cycles later.
- A write is visible on mem_data_out in the same cycle as ack.
- Minimum spacing between accepted requests: ACK_LATENCY+2 cycles (ACK, HOLD, IDLE).
- mem_data_out is registered only and carries no combinational path from inputs.
- hw_set takes effect on mem_data_out one cycle after it is asserted.

## Structure
- Package sd_reg_pkg: the state enum (ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD) and the access enum (ACC_RW, ACC_RO, ACC_W1C).
- Sub-module sd_reg_cell: one register with access-mode update logic and collision priority, instantiated NUM_REGS times by a generate loop. Its access mode is resolved from RO_MASK and W1C_MASK.
- Top level: the FSM, latency counter, address decode, read mux, and err generation.

## Test plan
- Reset with RESET_VALUES reg3=0xA5 -> mem_data_out slice 3 = 0xA5; ack, err, data_out = 0.
- ACK_LATENCY=3, write 0x5C to reg 2 (RW) -> ack exactly 3 cycles after req; wr_pulse[2] pulses; a read of reg 2 returns 0x5C.
- Reg 5 W1C holding 0xFF: host writes 0x0F while hw_set[5] with hw_data 0x01 on the same edge -> reg 5 = 0xF1.
- Write 0x77 to RO reg 7 -> value unchanged, ack=1, err=0, no wr_pulse; hw_set[7] with 0x33 -> reads return 0x33.
- NUM_REGS=12, read address 13 -> ack=1, err=1, data_out=0; write to address 13 -> no register changes.
- Assert reset in WAIT mid-write to reg 1 -> no ack, reg 1 = reset value; req held high across reset is re-accepted after release.

Source files
------------

// File: rtl/sd_reg_pkg.sv
// Shared types for the SD host register bank: handshake FSM states and
// per-register host access modes.
package sd_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_t;

endpackage

// File: rtl/sd_reg_cell.sv
// One bank register: host write and hardware update merged according to the
// register's access mode, with host-over-hw (RW) and set-over-clear (W1C) priority.
module sd_reg_cell
  import sd_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter acc_t                  ACC        = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_we,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  hw_set,
  input  logic [DATA_WIDTH-1:0] hw_data,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      case (ACC)
        ACC_RW: begin
          if (host_we)     q <= host_data;
          else if (hw_set) q <= hw_data;
        end
        ACC_RO: begin
          if (hw_set) q <= hw_data;
        end
        default: begin
          // Clear first, then OR the set so a same-edge set wins per bit.
          q <= (q & ~(host_we ? host_data : '0)) | (hw_set ? hw_data : '0);
        end
      endcase
    end
  end

endmodule

// File: rtl/sd_reg_bank.sv
// Host-facing SD register bank: four-phase req/ack FSM with programmable ack
// latency, address decode, read mux and per-register cells.
module sd_reg_bank
  import sd_reg_pkg::*;
#(
  parameter int                              DATA_WIDTH   = 8,
  parameter int                              ADDR_WIDTH   = 4,
  parameter int                              NUM_REGS     = 16,
  parameter int                              ACK_LATENCY  = 1,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0]  RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0]             RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]             W1C_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic                           wnr,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [NUM_REGS-1:0]            hw_set,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] hw_data,
  output logic                           ack,
  output logic                           err,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [DATA_WIDTH*NUM_REGS-1:0] mem_data_out
);

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  state_t                  state_reg;
  logic [1:0]              cnt_reg;
  logic                    wnr_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;

  logic                    commit;
  logic                    cur_wnr;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic                    addr_ok;
  logic [NUM_REGS-1:0]     sel;
  logic [NUM_REGS-1:0]     host_we;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   rd_data;

  // With a latency of one the access commits on the accepting edge, so the
  // live bus is used; otherwise the latched copy is.
  always_comb begin
    cur_wnr  = (state_reg == ST_IDLE) ? wnr     : wnr_reg;
    cur_addr = (state_reg == ST_IDLE) ? address : addr_reg;
    cur_data = (state_reg == ST_IDLE) ? data_in : data_reg;
    commit   = ((state_reg == ST_IDLE) && req && (ACK_LATENCY == 1)) ||
               ((state_reg == ST_WAIT) && (cnt_reg == 2'd0));
    addr_ok  = ({1'b0, cur_addr} < NUM_REGS_W);
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
      localparam acc_t ACC_MODE = RO_MASK[gi]  ? ACC_RO  :
                                  W1C_MASK[gi] ? ACC_W1C : ACC_RW;

      assign sel[gi]     = (cur_addr == IDX);
      assign host_we[gi] = commit && cur_wnr && sel[gi];

      sd_reg_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC        (ACC_MODE),
        .RESET_VAL  (RESET_VALUES[DATA_WIDTH*gi +: DATA_WIDTH])
      ) u_cell (
        .clk       (clk),
        .reset     (reset),
        .host_we   (host_we[gi]),
        .host_data (cur_data),
        .hw_set    (hw_set[gi]),
        .hw_data   (hw_data[DATA_WIDTH*gi +: DATA_WIDTH]),
        .q         (regs[gi])
      );

      assign mem_data_out[DATA_WIDTH*gi +: DATA_WIDTH] = regs[gi];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) rd_data = regs[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wnr_reg   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
      wr_pulse  <= '0;
    end else begin
      ack      <= 1'b0;
      err      <= 1'b0;
      wr_pulse <= '0;
      if (commit) begin
        ack      <= 1'b1;
        err      <= !addr_ok;
        wr_pulse <= host_we & ~RO_MASK;
        if (!cur_wnr) data_out <= addr_ok ? rd_data : '0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            wnr_reg  <= wnr;
            addr_reg <= address;
            data_reg <= data_in;
            if (ACK_LATENCY == 1) begin
              state_reg <= ST_ACK;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= 2'(ACK_LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 2'd0) state_reg <= ST_ACK;
          else                 cnt_reg   <= cnt_reg - 2'd1;
        end
        ST_ACK:  state_reg <= ST_HOLD;
        default: if (!req) state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
